fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID register, sitting directly downstream of the program counter. Each cycle it drives the current PC to instruction memory and takes the returned 16-bit word. It assembles one-word and two-word (immediate-carrying) instructions into a 32-bit packet and presents it, with its PC and a valid flag, to decode. It honours the pipeline's stall and flush controls.

## Interface
- `ADDR_W`, default 12: instruction-memory address width; low bits of PC.
- `clk` input, 1: clock; all state updates on rising edge.
- `reset` input, 1: asynchronous, active-low reset.
- `pc` input, 32: current PC from the program counter.
- `mem_data` input, 16: instruction word read combinationally at `mem_addr`.
- `stall` input, 1: hold all stage state.
- `flush` input, 1: discard in-flight fetch; has priority over `stall`.
- `mem_addr` output, ADDR_W: `pc[ADDR_W-1:0]`, combinational.
- `if_instr` output, 32: {first word, immediate word}. One-word instructions have the low half 16'h0000.
- `if_pc` output, 32: PC of the first word of `if_instr`.
- `if_valid` output, 1: `if_instr`/`if_pc` hold a complete instruction.
- `if_two_word` output, 1: registered copy of the two-word flag for the current packet.
- `stall_count` output, 16: present only with `FETCH_STATS_EN`.

## Operation
- Two-word marker: `mem_data[15]==1` on a first word means the next sequential word is its immediate.
- States: `S_FIRST` (expecting an opcode word) and `S_SECOND` (expecting an immediate).
- `S_FIRST`, no stall/flush, `mem_data[15]==0`: `if_instr<={mem_data,16'h0}`, `if_pc<=pc`, `if_valid<=1`, `if_two_word<=0`. Stay in `S_FIRST`.
- `S_FIRST`, no stall/flush, `mem_data[15]==1`: `hi_word<=mem_data`, `hi_pc<=pc`, `if_valid<=0` (bubble), go to `S_SECOND`. `if_instr`/`if_pc` hold.
- `S_SECOND`, no stall/flush: `if_instr<={hi_word,mem_data}`, `if_pc<=hi_pc`, `if_valid<=1`, `if_two_word<=1`, go to `S_FIRST`. `mem_data[15]` is ignored in this state.
- `stall==1`, `flush==0`: every register holds, including state, `if_valid`, `hi_word` and `hi_pc`.
- `flush==1` (regardless of `stall`): `if_valid<=0`, `if_instr<=0`, `if_two_word<=0`, state `<=S_FIRST`; `hi_word`/`hi_pc` are don't-care.
- Reset (`reset==0`, asynchronous): state `S_FIRST`; `if_instr`, `if_pc`, `hi_word`, `hi_pc` = 0; `if_valid`, `if_two_word` = 0; `stall_count` = 0. The first fetch occurs on the first rising edge after `reset` deasserts.
- Reset asserted mid two-word fetch: the half-assembled instruction is dropped and no packet is emitted.
- `mem_addr` truncates the PC with no range check.

## Timing
- Latency, one-word instruction: 1 cycle from `pc` to valid `if_instr`.
- Latency, two-word instruction: 2 cycles. The bubble cycle shows `if_valid==0`.
- `stall` and `flush` are sampled at the same edge as `mem_data`.
- A stall during `S_SECOND` keeps `hi_word` until the edge at which `stall` drops. The upstream PC holds while stalled, so `mem_data` is still the immediate at that edge.
- A flush takes effect at the edge it is sampled. The word fetched in that cycle is discarded.

## Configuration
- `FETCH_STATS_EN` defined: adds the `stall_count` port.
  - Increments by 1 at each rising edge where `stall==1 && flush==0`.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- `FETCH_STATS_EN` undefined: no port, no counter logic; behaviour otherwise identical.

## Test plan
- Reset, then `pc`=0x20, `mem_data`=16'h1234 → after 1 edge: `if_valid`=1, `if_instr`=32'h1234_0000, `if_pc`=0x20, `if_two_word`=0.
- `pc`=0x21, `mem_data`=16'h8A01, then `pc`=0x22, `mem_data`=16'h00FF → edge 1: `if_valid`=0; edge 2: `if_instr`=32'h8A01_00FF, `if_pc`=0x21, `if_two_word`=1.
- Two-word fetch with `stall`=1 for 3 cycles while in `S_SECOND`, then `mem_data`=16'hBEEF with stall released → outputs frozen during the stall, then `if_instr`={first word,16'hBEEF}. With `FETCH_STATS_EN`, `stall_count`=3.
- `flush` and `stall` both 1 while in `S_SECOND` → next edge `if_valid`=0, state `S_FIRST`. A following `mem_data`=16'h0042 yields `if_instr`=32'h0042_0000.
- `reset` pulsed low between edges while in `S_SECOND` → outputs zero immediately without a clock edge. After release, no stale immediate packet appears.
- With `FETCH_STATS_EN`: hold `stall`=1 for 65540 cycles → `stall_count` stays 16'hFFFF.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register; assembles 1- and 2-word instrs.
// Optional stall statistics counter: define FETCH_STATS_EN.
package fetch_pkg;

  typedef enum logic {
    S_FIRST  = 1'b0,
    S_SECOND = 1'b1
  } fstate_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        two_word;
  } if_id_t;

endpackage

module fetch_stage
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pc,
  input  logic [15:0]       mem_data,
  input  logic              stall,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_pc,
  output logic              if_valid,
`ifdef FETCH_STATS_EN
  output logic              if_two_word,
  output logic [15:0]       stall_count
`else
  output logic              if_two_word
`endif
);

  fstate_t     state_q;
  fstate_t     state_d;
  if_id_t      pkt_q;
  if_id_t      pkt_d;
  logic [15:0] hi_word_q;
  logic [15:0] hi_word_d;
  logic [31:0] hi_pc_q;
  logic [31:0] hi_pc_d;
  logic        advance;
  logic        marker;

  assign advance = !flush && !stall;
  assign marker  = mem_data[15];

  assign mem_addr = pc[ADDR_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FIRST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_FIRST;
    end else if (advance) begin
      unique case (state_q)
        S_FIRST:  state_d = marker ? S_SECOND : S_FIRST;
        S_SECOND: state_d = S_FIRST;
        default:  state_d = S_FIRST;
      endcase
    end
  end

  // Next packet and pending opcode half; stall leaves everything as is.
  always_comb begin
    pkt_d     = pkt_q;
    hi_word_d = hi_word_q;
    hi_pc_d   = hi_pc_q;
    if (flush) begin
      pkt_d.instr    = 32'h0;
      pkt_d.valid    = 1'b0;
      pkt_d.two_word = 1'b0;
    end else if (advance) begin
      unique case (state_q)
        S_FIRST: begin
          if (marker) begin
            hi_word_d   = mem_data;
            hi_pc_d     = pc;
            pkt_d.valid = 1'b0;
          end else begin
            pkt_d.instr    = {mem_data, 16'h0000};
            pkt_d.pc       = pc;
            pkt_d.valid    = 1'b1;
            pkt_d.two_word = 1'b0;
          end
        end
        S_SECOND: begin
          pkt_d.instr    = {hi_word_q, mem_data};
          pkt_d.pc       = hi_pc_q;
          pkt_d.valid    = 1'b1;
          pkt_d.two_word = 1'b1;
        end
        default: begin
          pkt_d.valid = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_q     <= '0;
      hi_word_q <= 16'h0;
      hi_pc_q   <= 32'h0;
    end else begin
      pkt_q     <= pkt_d;
      hi_word_q <= hi_word_d;
      hi_pc_q   <= hi_pc_d;
    end
  end

  assign if_instr    = pkt_q.instr;
  assign if_pc       = pkt_q.pc;
  assign if_valid    = pkt_q.valid;
  assign if_two_word = pkt_q.two_word;

`ifdef FETCH_STATS_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 16'h0;
    end else if (stall && !flush && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'h1;
    end
  end

  assign stall_count = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: driver queues per-cycle expectations,
// monitor compares them against the IF/ID outputs.
module tb_fetch_stage;

  typedef struct {
    int          id;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        two;
    bit          chk_pc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [15:0] mem_data;
  logic        stall;
  logic        flush;
  logic [11:0] mem_addr;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        if_two_word;
`ifdef FETCH_STATS_EN
  logic [15:0] stall_count;
`endif

  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;
  exp_t sb[$];

  fetch_stage #(.ADDR_W(12)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .mem_data    (mem_data),
    .stall       (stall),
    .flush       (flush),
    .mem_addr    (mem_addr),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_valid    (if_valid),
`ifdef FETCH_STATS_EN
    .if_two_word (if_two_word),
    .stall_count (stall_count)
`else
    .if_two_word (if_two_word)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (if_instr !== e.instr || if_valid !== e.valid ||
          if_two_word !== e.two ||
          (e.chk_pc && if_pc !== e.pc)) begin
        errors++;
        $display("FAIL pkt%0d got instr=%h pc=%h v=%b tw=%b exp instr=%h pc=%h v=%b tw=%b",
                 e.id, if_instr, if_pc, if_valid, if_two_word,
                 e.instr, e.pc, e.valid, e.two);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step(input logic [31:0] p, input logic [15:0] d,
                      input logic s, input logic f,
                      input logic [31:0] ei, input logic [31:0] ep,
                      input logic ev, input logic et, input bit cp);
    exp_t e;
    pc       = p;
    mem_data = d;
    stall    = s;
    flush    = f;
    @(posedge clk);
    e.id     = step_id;
    e.instr  = ei;
    e.pc     = ep;
    e.valid  = ev;
    e.two    = et;
    e.chk_pc = cp;
    sb.push_back(e);
    step_id++;
    @(negedge clk);
  endtask

  initial begin
    reset    = 1'b0;
    pc       = 32'h0;
    mem_data = 16'h0;
    stall    = 1'b0;
    flush    = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_instr", if_instr, 32'h0);
    chk("reset_flags", {30'h0, if_valid, if_two_word}, 32'h0);
    reset = 1'b1;

    step(32'h20, 16'h1234, 0, 0, 32'h1234_0000, 32'h20, 1, 0, 1);
    step(32'h21, 16'h8A01, 0, 0, 32'h1234_0000, 32'h20, 0, 0, 1);
    step(32'h22, 16'h00FF, 0, 0, 32'h8A01_00FF, 32'h21, 1, 1, 1);
    step(32'h30, 16'h0005, 0, 0, 32'h0005_0000, 32'h30, 1, 0, 1);

    step(32'h40, 16'h9ABC, 0, 0, 32'h0005_0000, 32'h30, 0, 0, 1);
    repeat (3)
      step(32'h41, 16'h7777, 1, 0, 32'h0005_0000, 32'h30, 0, 0, 1);
    step(32'h41, 16'hBEEF, 0, 0, 32'h9ABC_BEEF, 32'h40, 1, 1, 1);
`ifdef FETCH_STATS_EN
    chk("stall_count_3", {16'h0, stall_count}, 32'd3);
`endif

    step(32'h50, 16'h0011, 1, 0, 32'h9ABC_BEEF, 32'h40, 1, 1, 1);
    step(32'h50, 16'h0011, 0, 0, 32'h0011_0000, 32'h50, 1, 0, 1);

    step(32'h60, 16'h8123, 0, 0, 32'h0011_0000, 32'h50, 0, 0, 1);
    step(32'h61, 16'h00AA, 1, 1, 32'h0, 32'h0, 0, 0, 0);
    step(32'h62, 16'h0042, 0, 0, 32'h0042_0000, 32'h62, 1, 0, 1);
`ifdef FETCH_STATS_EN
    chk("stall_count_flush", {16'h0, stall_count}, 32'd4);
`endif

    step(32'h70, 16'h0099, 0, 1, 32'h0, 32'h0, 0, 0, 0);
    step(32'h71, 16'h8000, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    step(32'h72, 16'h8001, 0, 0, 32'h8000_8001, 32'h71, 1, 1, 1);
    step(32'h73, 16'h0003, 0, 0, 32'h0003_0000, 32'h73, 1, 0, 1);

    step(32'h80, 16'h8555, 0, 0, 32'h0003_0000, 32'h73, 0, 0, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_instr", if_instr, 32'h0);
    chk("async_rst_pc", if_pc, 32'h0);
    chk("async_rst_flags", {30'h0, if_valid, if_two_word}, 32'h0);
`ifdef FETCH_STATS_EN
    chk("async_rst_cnt", {16'h0, stall_count}, 32'h0);
`endif
    #1 reset = 1'b1;
    step(32'h81, 16'h0777, 0, 0, 32'h0777_0000, 32'h81, 1, 0, 1);

    pc = 32'hFFFF_FABC;
    #1;
    chk("mem_addr_trunc", {20'h0, mem_addr}, 32'h0000_0ABC);

`ifdef FETCH_STATS_EN
    stall    = 1'b1;
    mem_data = 16'h0001;
    repeat (65540) @(posedge clk);
    @(negedge clk);
    chk("stall_count_sat", {16'h0, stall_count}, 32'h0000_FFFF);
    stall = 1'b0;
`endif

    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
